// File: rtl/sample_sequencer.sv
// sample_sequencer: serializes labelled samples onto the device input bus,
// tracks labels of samples in flight and scores returned classifications.
// Latency: first beat the cycle after accept; result reported the cycle after dev_outp_vld.
module sample_sequencer #(
  parameter int SAMPLE_BITS  = 784,
  parameter int BUS_WIDTH    = 64,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_vld,
  output logic                          s_rdy,
  input  logic [SAMPLE_BITS-1:0]        s_data,
  input  logic [7:0]                    s_label,
  output logic                          dev_inp_vld,
  output logic [BUS_WIDTH-1:0]          dev_inp,
  input  logic                          dev_stall,
  input  logic                          dev_outp_vld,
  input  logic [3:0]                    dev_outp,
  output logic                          res_vld,
  output logic [3:0]                    res_class,
  output logic [7:0]                    res_label,
  output logic                          res_correct,
  input  logic                          clear,
  output logic [CNT_WIDTH-1:0]          correct_cnt,
  output logic [CNT_WIDTH-1:0]          total_cnt,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          busy,
  output logic                          err
);

  localparam int BEATS   = (SAMPLE_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = $clog2(MAX_INFLIGHT);
  localparam int FILL_W  = PTR_W + 1;
  localparam int PADDED  = BEATS * BUS_WIDTH;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [PADDED-1:0]   sample_q;

  logic [7:0]          label_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic                last_beat;
  logic                xfer;
  logic                pop;
  logic                spurious;
  logic                room;
  logic                accept;
  logic [7:0]          head_label;
  logic                match;

  // Handshake decode; pop frees a FIFO slot in the same cycle so a full
  // FIFO can take a new sample while a result is returning.
  always_comb begin
    last_beat   = (beat == BEAT_W'(BEATS - 1));
    dev_inp_vld = rst && (state == STREAM);
    dev_inp     = sample_q[int'(beat) * BUS_WIDTH +: BUS_WIDTH];
    xfer        = dev_inp_vld && !dev_stall;
    pop         = dev_outp_vld && (inflight != '0);
    spurious    = dev_outp_vld && (inflight == '0);
    room        = (inflight < FILL_W'(MAX_INFLIGHT)) || pop;
    head_label  = label_mem[rd_ptr];
    match       = ({4'b0, dev_outp} == head_label);
    busy        = (state == STREAM) || (inflight != '0);
    s_rdy       = 1'b0;
    if (rst) begin
      if (state == IDLE) s_rdy = room;
      else               s_rdy = last_beat && !dev_stall && room;
    end
    accept      = s_vld && s_rdy;
  end

  // Streaming FSM: latch a sample on accept, walk its beats, chain the
  // next sample on the last-beat transfer for gapless output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      sample_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sample_q <= PADDED'(s_data);
            beat     <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_beat) begin
              beat <= '0;
              if (accept) sample_q <= PADDED'(s_data);
              else        state    <= IDLE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Label storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (accept) label_mem[wr_ptr] <= s_label;
  end

  // Label FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      inflight <= inflight + FILL_W'(accept) - FILL_W'(pop);
    end
  end

  // Result reporting, saturating score counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_vld     <= 1'b0;
      res_class   <= '0;
      res_label   <= '0;
      res_correct <= 1'b0;
      correct_cnt <= '0;
      total_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      res_vld <= pop;
      if (pop) begin
        res_class   <= dev_outp;
        res_label   <= head_label;
        res_correct <= match;
      end
      if (clear) begin
        correct_cnt <= '0;
        total_cnt   <= '0;
        err         <= 1'b0;
      end else begin
        if (pop) begin
          if (total_cnt != '1)            total_cnt   <= total_cnt + CNT_WIDTH'(1);
          if (match && correct_cnt != '1) correct_cnt <= correct_cnt + CNT_WIDTH'(1);
        end
        if (spurious) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: directed sequences with a cycle-level scoreboard
// that predicts beats, handshakes, FIFO occupancy, results and counters.
module tb_sample_sequencer;

  localparam int SB = 100;
  localparam int BW = 32;
  localparam int MI = 4;
  localparam int CW = 3;
  localparam int NB = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_vld = 1'b0;
  logic          s_rdy;
  logic [SB-1:0] s_data = '0;
  logic [7:0]    s_label = '0;
  logic          dev_inp_vld;
  logic [BW-1:0] dev_inp;
  logic          dev_stall = 1'b0;
  logic          dev_outp_vld = 1'b0;
  logic [3:0]    dev_outp = '0;
  logic          res_vld;
  logic [3:0]    res_class;
  logic [7:0]    res_label;
  logic          res_correct;
  logic          clear = 1'b0;
  logic [CW-1:0] correct_cnt;
  logic [CW-1:0] total_cnt;
  logic [2:0]    inflight;
  logic          busy;
  logic          err;

  sample_sequencer #(.SAMPLE_BITS(SB), .BUS_WIDTH(BW), .MAX_INFLIGHT(MI), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data), .s_label(s_label),
    .dev_inp_vld(dev_inp_vld), .dev_inp(dev_inp), .dev_stall(dev_stall),
    .dev_outp_vld(dev_outp_vld), .dev_outp(dev_outp),
    .res_vld(res_vld), .res_class(res_class), .res_label(res_label), .res_correct(res_correct),
    .clear(clear), .correct_cnt(correct_cnt), .total_cnt(total_cnt),
    .inflight(inflight), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int run_len = 0;
  int last_run = 0;
  bit mon_en = 1'b0;

  // scoreboard state
  logic [7:0]  lbl_q [$];
  logic [31:0] beat_q [$];
  logic        m_res_vld = 1'b0;
  logic [3:0]  m_cls = '0;
  logic [7:0]  m_lbl = '0;
  logic        m_corr = 1'b0;
  int          m_correct = 0;
  int          m_total = 0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model by one clock.
  task automatic model_step();
    logic       exp_vld, exp_rdy, room, pop, spur, corr;
    logic [7:0] lbl;
    logic [127:0] pd;
    chk("inflight", 64'(inflight), 64'(lbl_q.size()));
    chk("correct_cnt", 64'(correct_cnt), 64'(m_correct));
    chk("total_cnt", 64'(total_cnt), 64'(m_total));
    chk("err", 64'(err), 64'(m_err));
    chk("res_vld", 64'(res_vld), 64'(m_res_vld));
    if (m_res_vld) begin
      chk("res_class", 64'(res_class), 64'(m_cls));
      chk("res_label", 64'(res_label), 64'(m_lbl));
      chk("res_correct", 64'(res_correct), 64'(m_corr));
    end
    exp_vld = rst && (beat_q.size() != 0);
    pop     = dev_outp_vld && (lbl_q.size() != 0);
    room    = (lbl_q.size() < MI) || pop;
    if (!rst)                    exp_rdy = 1'b0;
    else if (beat_q.size() == 0) exp_rdy = room;
    else                         exp_rdy = (beat_q.size() == 1) && !dev_stall && room;
    chk("s_rdy", 64'(s_rdy), 64'(exp_rdy));
    chk("dev_inp_vld", 64'(dev_inp_vld), 64'(exp_vld));
    chk("busy", 64'(busy), 64'((beat_q.size() != 0) || (lbl_q.size() != 0)));
    if (exp_vld) chk("dev_inp", 64'(dev_inp), 64'(beat_q[0]));
    if (dev_inp_vld) begin
      vld_cnt++;
      run_len++;
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (!rst) begin
      lbl_q.delete();
      beat_q.delete();
      m_res_vld = 1'b0;
      m_correct = 0;
      m_total   = 0;
      m_err     = 1'b0;
    end else begin
      spur = dev_outp_vld && (lbl_q.size() == 0);
      corr = 1'b0;
      m_res_vld = pop;
      if (pop) begin
        lbl    = lbl_q.pop_front();
        corr   = ({4'b0, dev_outp} == lbl);
        m_cls  = dev_outp;
        m_lbl  = lbl;
        m_corr = corr;
      end
      if (clear) begin
        m_correct = 0;
        m_total   = 0;
        m_err     = 1'b0;
      end else begin
        if (pop) begin
          if (m_total < SAT) m_total++;
          if (corr && m_correct < SAT) m_correct++;
        end
        if (spur) m_err = 1'b1;
      end
      if (exp_vld && !dev_stall) void'(beat_q.pop_front());
      if (s_vld && exp_rdy) begin
        lbl_q.push_back(s_label);
        pd = 128'(s_data);
        for (int j = 0; j < NB; j++) beat_q.push_back(pd[j*BW +: BW]);
      end
    end
  endtask

  // Sample everything mid-low-phase, after the driver has settled inputs.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) model_step();
  end

  function automatic logic [SB-1:0] rnd();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[SB-1:0];
  endfunction

  task automatic send(input logic [SB-1:0] d, input logic [7:0] l);
    int n = 0;
    s_vld = 1'b1; s_data = d; s_label = l;
    #1;
    while (!s_rdy && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("send_bound", 64'(n < 200), 64'(1));
    @(negedge clk);
    s_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (dev_inp_vld && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("idle_bound", 64'(n < 200), 64'(1));
    @(negedge clk);
  endtask

  task automatic pulse_result(input logic [3:0] cls, input logic clr);
    dev_outp_vld = 1'b1; dev_outp = cls; clear = clr;
    @(negedge clk);
    dev_outp_vld = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [SB-1:0] d1;
    logic [31:0]   exp_b [4];
    int            v0;
    d1 = 100'h5_89AB_CDEF_0123_4567_DEAD_BEEF;
    exp_b = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000005};

    // reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    #1;
    chk("rst_s_rdy", 64'(s_rdy), 64'(0));
    chk("rst_inp_vld", 64'(dev_inp_vld), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single sample, label 3
    v0 = vld_cnt;
    send(d1, 8'd3);
    for (int k = 0; k < NB; k++) begin
      #1 chk("single_beat", 64'(dev_inp), 64'(exp_b[k]));
      @(negedge clk);
    end
    #1;
    chk("single_idle", 64'(dev_inp_vld), 64'(0));
    chk("single_inflight", 64'(inflight), 64'(1));
    chk("single_cycles", 64'(vld_cnt - v0), 64'(4));
    pulse_result(4'd3, 1'b0);
    #1;
    chk("single_res_vld", 64'(res_vld), 64'(1));
    chk("single_res_correct", 64'(res_correct), 64'(1));
    chk("single_correct_cnt", 64'(correct_cnt), 64'(1));
    chk("single_total_cnt", 64'(total_cnt), 64'(1));
    @(negedge clk);

    // stall three cycles on beat 1
    v0 = vld_cnt;
    send(d1, 8'd5);
    @(negedge clk);
    dev_stall = 1'b1;
    repeat (3) begin
      #1 chk("stall_hold", 64'(dev_inp), 64'(32'h01234567));
      @(negedge clk);
    end
    dev_stall = 1'b0;
    #1 chk("stall_release", 64'(dev_inp), 64'(32'h01234567));
    wait_idle();
    chk("stall_cycles", 64'(vld_cnt - v0), 64'(7));
    pulse_result(4'd5, 1'b0);
    #1 chk("stall_total", 64'(total_cnt), 64'(2));
    @(negedge clk);

    // back-to-back, labels 1,2,2
    send(rnd(), 8'd1);
    send(rnd(), 8'd2);
    send(rnd(), 8'd2);
    wait_idle();
    chk("b2b_run", 64'(last_run), 64'(12));
    chk("b2b_inflight", 64'(inflight), 64'(3));

    // scoring after clear: outp 1,0,2 against labels 1,2,2
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse_result(4'd1, 1'b0);
    pulse_result(4'd0, 1'b0);
    pulse_result(4'd2, 1'b0);
    #1;
    chk("score_correct", 64'(correct_cnt), 64'(2));
    chk("score_total", 64'(total_cnt), 64'(3));
    @(negedge clk);
    send(rnd(), 8'd7);
    wait_idle();
    pulse_result(4'd7, 1'b1);
    #1;
    chk("clear_win_correct", 64'(correct_cnt), 64'(0));
    chk("clear_win_total", 64'(total_cnt), 64'(0));
    chk("clear_win_res_vld", 64'(res_vld), 64'(1));
    @(negedge clk);

    // fill FIFO
    for (int i = 4; i < 8; i++) send(rnd(), 8'(i));
    wait_idle();
    #1;
    chk("full_s_rdy", 64'(s_rdy), 64'(0));
    chk("full_inflight", 64'(inflight), 64'(4));
    pulse_result(4'd4, 1'b0);
    #1;
    chk("full_pop_inflight", 64'(inflight), 64'(3));
    chk("full_pop_s_rdy", 64'(s_rdy), 64'(1));
    @(negedge clk);
    for (int i = 5; i < 8; i++) pulse_result(4'(i), 1'b0);

    // counters saturate at all-ones
    for (int i = 1; i < 5; i++) send(rnd(), 8'(i));
    wait_idle();
    for (int i = 1; i < 5; i++) pulse_result(4'(i), 1'b0);
    #1;
    chk("sat_total", 64'(total_cnt), 64'(SAT));
    chk("sat_correct", 64'(correct_cnt), 64'(SAT));
    @(negedge clk);

    // spurious result with empty FIFO
    pulse_result(4'd2, 1'b0);
    #1;
    chk("spur_err", 64'(err), 64'(1));
    chk("spur_total", 64'(total_cnt), 64'(SAT));
    chk("spur_res_vld", 64'(res_vld), 64'(0));
    @(negedge clk);

    // reset during beat 2
    send(rnd(), 8'd9);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_inp_vld", 64'(dev_inp_vld), 64'(0));
    chk("rst_mid_inflight", 64'(inflight), 64'(0));
    chk("rst_mid_err", 64'(err), 64'(0));
    chk("rst_mid_total", 64'(total_cnt), 64'(0));
    @(negedge clk);
    send(d1, 8'd3);
    #1 chk("fresh_beat0", 64'(dev_inp), 64'(32'hDEADBEEF));
    wait_idle();
    pulse_result(4'd3, 1'b0);
    #1 chk("fresh_total", 64'(total_cnt), 64'(1));
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
